// File: rtl/ram_fifo_ctrl.sv
// Ready/valid FIFO built around a single-port-pair synchronous RAM.
// The RAM read register doubles as the output stage, so the FIFO holds
// depth_p entries in the array plus one in the read register.

module ram_1r1w_sync #(
  parameter int width_p = 8,
  parameter int depth_p = 16,
  localparam int addr_w = $clog2(depth_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_valid_i,
  input  logic [addr_w-1:0] wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic              rd_valid_i,
  input  logic [addr_w-1:0] rd_addr_i,
  output logic [width_p-1:0] rd_data_o
);

  logic [width_p-1:0] mem [depth_p];

  // Storage array: written only on an enabled write, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Read register: cleared on reset, loaded only on an enabled read, else holds.
  always_ff @(posedge clk_i) begin
    if (reset_i)         rd_data_o <= '0;
    else if (rd_valid_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

module ram_fifo_ctrl #(
  parameter int width_p = 8,
  parameter int depth_p = 16,
  localparam int addr_w  = $clog2(depth_p),
  localparam int cnt_w   = $clog2(depth_p + 1),
  localparam int count_w = $clog2(depth_p + 2)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic [count_w-1:0] count_o
);

  localparam logic [cnt_w-1:0]  depth_c = cnt_w'(depth_p);
  localparam logic [addr_w-1:0] last_c  = addr_w'(depth_p - 1);

  logic [addr_w-1:0] wr_ptr;
  logic [addr_w-1:0] rd_ptr;
  logic [cnt_w-1:0]  ram_cnt;
  logic              push;
  logic              pop;
  logic              fetch;

  // ram_cnt only counts writes committed at earlier edges, so a fetch
  // never targets the slot being written this cycle; no bypass needed.
  assign ready_o = reset_ni & (ram_cnt != depth_c);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign fetch   = (ram_cnt != '0) & (~valid_o | pop);
  assign count_o = count_w'(ram_cnt) + count_w'(valid_o);

  // Pointer, occupancy and output-valid bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      valid_o <= 1'b0;
    end else begin
      if (push)  wr_ptr <= (wr_ptr == last_c) ? '0 : wr_ptr + 1'b1;
      if (fetch) rd_ptr <= (rd_ptr == last_c) ? '0 : rd_ptr + 1'b1;
      ram_cnt <= ram_cnt + cnt_w'(push) - cnt_w'(fetch);
      if (fetch)    valid_o <= 1'b1;
      else if (pop) valid_o <= 1'b0;
    end
  end

  ram_1r1w_sync #(
    .width_p (width_p),
    .depth_p (depth_p)
  ) u_ram (
    .clk_i      (clk_i),
    .reset_i    (~reset_ni),
    .wr_valid_i (push),
    .wr_addr_i  (wr_ptr),
    .wr_data_i  (data_i),
    .rd_valid_i (fetch),
    .rd_addr_i  (rd_ptr),
    .rd_data_o  (data_o)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (width 8, depth 16).
module tb_ram_fifo_ctrl;

  logic       clk_i;
  logic       reset_ni;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
  logic [4:0] count_o;

  int total = 0;
  int bad   = 0;

  ram_fifo_ctrl #(.width_p(8), .depth_p(16)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .ready_i  (ready_i),
    .count_o  (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int in_val;
    int exp_out;
    logic [7:0] exp_b;

    // 1. reset held with valid_i high
    reset_ni = 1'b0; valid_i = 1'b1; data_i = 8'h77; ready_i = 1'b0;
    tick(); tick(); tick();
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_data",  data_o,  0);
    reset_ni = 1'b1; valid_i = 1'b0;
    tick();
    check("idle_ready", ready_o, 1);

    // 2. single push, two-cycle latency, stall stability
    valid_i = 1'b1; data_i = 8'hA5;
    tick();
    valid_i = 1'b0;
    check("lat1_valid", valid_o, 0);
    check("lat1_count", count_o, 1);
    tick();
    check("lat2_valid", valid_o, 1);
    check("lat2_data",  data_o,  8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", valid_o, 1);
      check("stall_data",  data_o,  8'hA5);
      check("stall_count", count_o, 1);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("pop1_valid", valid_o, 0);
    check("pop1_count", count_o, 0);

    // 3. fill to capacity 17, reject 18th, drain in order
    for (int i = 0; i < 17; i++) begin
      valid_i = 1'b1; data_i = 8'(i);
      check("fill_ready", ready_o, 1);
      tick();
    end
    check("full_count", count_o, 17);
    check("full_ready", ready_o, 0);
    data_i = 8'h11;
    tick();
    valid_i = 1'b0;
    check("reject_count", count_o, 17);
    ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", valid_o, 1);
      check("drain_data",  data_o,  8'(i));
      tick();
    end
    ready_i = 1'b0;
    check("drained_valid", valid_o, 0);
    check("drained_count", count_o, 0);

    // 4. streaming through with both sides always ready
    in_val = 0; exp_out = 0;
    valid_i = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      data_i = 8'(in_val);
      if (c >= 2) check("stream_count", count_o, 2);
      if (valid_o) begin
        check("stream_data", data_o, 8'(exp_out));
        exp_out++;
      end
      if (ready_o) in_val++;
      tick();
    end
    check("stream_pops", exp_out, 38);
    valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (valid_o) begin
        check("stream_tail", data_o, 8'(exp_out));
        exp_out++;
      end
      tick();
    end
    ready_i = 1'b0;
    check("stream_total", exp_out, 40);
    check("stream_empty", count_o, 0);

    // 5. pop and push together at full
    for (int i = 0; i < 17; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h50 + i);
      tick();
    end
    check("full5_count", count_o, 17);
    data_i = 8'hEE; ready_i = 1'b1;
    check("full5_ready", ready_o, 0);
    tick();
    ready_i = 1'b0;
    check("after_pop_count", count_o, 16);
    check("after_pop_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    check("refill_count", count_o, 17);
    ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_b = (i < 16) ? 8'(8'h51 + i) : 8'hEE;
      check("full5_drain", data_o, exp_b);
      tick();
    end
    ready_i = 1'b0;
    check("full5_empty", valid_o, 0);

    // 6. reset mid-stream discards everything
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h10 + i);
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("mid_head0", data_o, 8'h10);
    tick();
    check("mid_head1", data_o, 8'h11);
    tick();
    reset_ni = 1'b0; valid_i = 1'b1; data_i = 8'h99;
    tick();
    check("mid_rst_count", count_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_data",  data_o,  0);
    reset_ni = 1'b1; valid_i = 1'b1; ready_i = 1'b0; data_i = 8'h3C;
    tick();
    valid_i = 1'b0;
    check("post_rst_v1", valid_o, 0);
    check("post_rst_c1", count_o, 1);
    tick();
    check("post_rst_valid", valid_o, 1);
    check("post_rst_data",  data_o,  8'h3C);
    check("post_rst_count", count_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
